// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_pkg
//  Purpose  : Shared constants and helpers for the packed-BCD counter.
//             Digit limits, a nibble validity test and a width helper
//             for counters built from DIGITS packed BCD digits.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package bcd_pkg;

  localparam logic [3:0] BCD_MAX    = 4'd9;
  localparam logic [3:0] BCD_MIN    = 4'd0;
  localparam int         DIGITS_MAX = 8;

  // True when the nibble is a legal decimal digit (0..9).
  function automatic logic is_bcd(input logic [3:0] nibble);
    return (nibble <= BCD_MAX);
  endfunction

  // Packed width of a counter holding the given number of digits.
  function automatic int count_width(input int digits);
    return 4 * digits;
  endfunction

endpackage : bcd_pkg
`default_nettype wire

// File: rtl/bcd_digit_step.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_digit_step
//  Purpose  : Combinational single-digit BCD incrementer/decrementer.
//             With cin low the digit passes through unchanged.
//  Ports    : digit      in  4  current BCD digit
//             up         in  1  1 = increment, 0 = decrement
//             cin        in  1  step request from the lower digit
//             next_digit out 4  digit value after the step
//             cout       out 1  carry/borrow into the next digit
//  Revision : 1.0  initial release
// ============================================================================
module bcd_digit_step
  import bcd_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       up,
  input  logic       cin,
  output logic [3:0] next_digit,
  output logic       cout
);

  always_comb begin
    next_digit = digit;
    cout       = 1'b0;
    if (cin) begin
      if (up) begin
        // The >= also folds any illegal nibble back to zero.
        if (digit >= BCD_MAX) begin
          next_digit = BCD_MIN;
          cout       = 1'b1;
        end else begin
          next_digit = digit + 4'd1;
        end
      end else begin
        if (digit == BCD_MIN) begin
          next_digit = BCD_MAX;
          cout       = 1'b1;
        end else if (digit > BCD_MAX) begin
          next_digit = BCD_MAX;
        end else begin
          next_digit = digit - 4'd1;
        end
      end
    end
  end

endmodule : bcd_digit_step
`default_nettype wire

// File: rtl/bcd_counter_n.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_counter_n
//  Purpose  : N-digit packed-BCD up/down counter with synchronous load,
//             wrap or saturate at the limits, and registered carry/error
//             pulses. Digit i lives in count[4*i+3:4*i].
//  Ports    : clk       in  1         rising-edge clock
//             rst_n     in  1         synchronous active-low reset
//             en        in  1         count enable (when STEP_EN=1)
//             up        in  1         1 = increment, 0 = decrement
//             load      in  1         synchronous load request
//             load_val  in  4*DIGITS  packed BCD value to load
//             count     out 4*DIGITS  registered count
//             carry     out 1         pulse on wrap/saturate event
//             err       out 1         pulse when a load is rejected
//             at_max    out 1         count is all 9s
//             at_min    out 1         count is all 0s
//  Revision : 1.0  initial release
// ============================================================================
module bcd_counter_n
  import bcd_pkg::*;
#(
  parameter int DIGITS  = 3,
  parameter int WRAP    = 1,
  parameter int STEP_EN = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  carry,
  output logic                  err,
  output logic                  at_max,
  output logic                  at_min
);

  localparam int   c_W         = count_width(DIGITS);
  localparam logic c_FREE_RUN  = (STEP_EN == 0);
  localparam logic c_WRAP      = (WRAP != 0);
  localparam logic [c_W-1:0] c_ALL_MAX = {DIGITS{BCD_MAX}};
  localparam logic [c_W-1:0] c_ALL_MIN = {DIGITS{BCD_MIN}};

  logic [c_W-1:0] r_count;
  logic           r_carry;
  logic           r_err;

  logic           w_step;
  logic           w_load_ok;
  logic           w_limit;
  logic [c_W-1:0] w_next;
  logic [DIGITS:0] w_cin;

  // Load has priority, so a step only happens with load low.
  assign w_step   = ~load & (en | c_FREE_RUN);
  assign w_cin[0] = w_step;
  // Ripple out of the top digit means every digit was at its limit.
  assign w_limit  = w_cin[DIGITS];

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      bcd_digit_step u_step (
        .digit      (r_count[4*gi +: 4]),
        .up         (up),
        .cin        (w_cin[gi]),
        .next_digit (w_next[4*gi +: 4]),
        .cout       (w_cin[gi+1])
      );
    end
  endgenerate

  always_comb begin
    w_load_ok = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      w_load_ok = w_load_ok & is_bcd(load_val[4*d +: 4]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= c_ALL_MIN;
      r_carry <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_carry <= 1'b0;
      r_err   <= 1'b0;
      if (load) begin
        // A rejected load leaves the count untouched so it stays BCD.
        if (w_load_ok) begin
          r_count <= load_val;
        end else begin
          r_err   <= 1'b1;
        end
      end else if (w_step) begin
        r_carry <= w_limit;
        // In saturate mode the limit event holds the count in place.
        if (!w_limit || c_WRAP) begin
          r_count <= w_next;
        end
      end
    end
  end

  assign count  = r_count;
  assign carry  = r_carry;
  assign err    = r_err;
  assign at_max = (r_count == c_ALL_MAX);
  assign at_min = (r_count == c_ALL_MIN);

endmodule : bcd_counter_n
`default_nettype wire
